alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Producer side of the integer ALU interface: decodes RV32I OP, OP-IMM, LUI and AUIPC instructions.
//  Selects operands and presents a registered {alu_e, alu_op, alu_a, alu_b} bundle to the ALU.
//  Sits between the register-read stage and the ALU/execute stage, with valid/ready on both sides.
//  Uses a 2-entry skid buffer so in_ready is registered and no bubble is lost under backpressure.
// PARAMETERS
//  DATA_WIDTH  32  operand and PC width; must be >= 32. Immediates are sign-extended to DATA_WIDTH.
// PORTS
//  clk          in   1           single clock; all state updates on rising edge
//  rst_n        in   1           synchronous, active-low reset
//  flush        in   1           discard every buffered entry (branch redirect)
//  in_valid     in   1           upstream bundle valid
//  in_ready     out  1           stage can accept a bundle this cycle
//  in_instr     in   32          instruction word
//  in_pc        in   DATA_WIDTH  instruction address
//  in_rs1_val   in   DATA_WIDTH  rs1 register value
//  in_rs2_val   in   DATA_WIDTH  rs2 register value
//  out_valid    out  1           issued bundle valid
//  out_ready    in   1           ALU/execute consumes the bundle
//  alu_e        out  1           ALU enable
//  alu_op       out  5           ALU operation code, from the shared ALU opcode header
//  alu_a        out  DATA_WIDTH  ALU operand A
//  alu_b        out  DATA_WIDTH  ALU operand B
//  out_rd       out  5           destination register index
//  out_wb_en    out  1           write back the result (0 when rd==0 or when illegal)
//  out_illegal  out  1           instruction is not decodable by this stage
// BEHAVIOUR
//  Reset: while rst_n=0, every output is 0, including in_ready and out_valid. in_ready=1 from the first cycle after release.
//  Transfers: a transfer happens on a cycle with valid&&ready. Latency is 1 cycle: an accepted bundle appears with out_valid=1 on the next cycle.
//  Buffer FSM:
//   EMPTY --accept--> ONE.
//   ONE --accept & !out_ready--> TWO.
//   ONE --!accept & out_ready--> EMPTY.
//   ONE --accept & out_ready--> ONE.
//   TWO --out_ready--> ONE.
//   in_ready = (state != TWO), registered. Outputs always come from the head entry, FIFO order.
//  Flush: the state goes to EMPTY on the next cycle and out_valid=0. A simultaneous in_valid is dropped; flush wins.
//  While out_valid=0, alu_e=0. Output fields hold their last value and are don't-care to consumers.
//  Decode, on in_instr[6:0]:
//   OP 0110011: A=rs1, B=rs2. funct3 000 -> ADD, or SUB if funct7=0100000. 001 SLL. 010 LTS. 011 LTU.
//    100 XOR. 101 SRL, or SRA if funct7=0100000. 110 OR. 111 AND.
//    funct7 other than 0000000 is illegal, except 0100000 with funct3 000 or 101.
//   OP-IMM 0010011: A=rs1, B=sext(instr[31:20]). Same funct3 map; there is no SUB.
//    Shifts: B = zero-extended instr[24:20].
//    SLLI requires instr[31:25]=0. funct3 101 requires instr[31:25]=0 (SRL) or 0100000 (SRA). Anything else is illegal.
//   LUI 0110111: op ADD, A=0, B=sext({instr[31:12],12'b0}).
//   AUIPC 0010111: op ADD, A=pc, B=sext({instr[31:12],12'b0}).
//   Any other opcode is illegal.
//  Illegal bundle: alu_e=0, alu_op=ADD, A=B=0, wb_en=0, illegal=1. It is still issued with out_valid=1 so the trap logic sees it in order.
//  out_rd = instr[11:7]; wb_en = legal && rd != 0.
//  Arithmetic: no arithmetic is done in this stage, only muxing and sign-extension. PC and register values pass through unmodified.
// STRUCTURE
//  Shared constants come from the existing ALU opcode header; this stage uses no new ALU codes.
//  New shared header: RV32I major-opcode and funct3/funct7 constants, reused by later decode stages.
//  Combinational decoder packs a bundle: {alu_op, a, b, rd, wb_en, illegal}.
//  One sub-module: alu_issue_skid, a generic 2-entry valid/ready skid buffer parameterised by bundle width.
// TESTING
//  1 Reset: hold rst_n=0 for 3 cycles with in_valid=1. Required: out_valid=0 and in_ready=0 throughout, then in_ready=1 on the first cycle after release.
//  2 Decode sweep: 0x40208033 (sub x0,x1,x2) with rs1=5, rs2=7.
//    Required: next cycle alu_op=SUB, A=5, B=7, alu_e=1, wb_en=0 (rd=0).
//  3 Decode sweep: 0xFFF00093 (addi x1,x0,-1) -> B=0xFFFFFFFF.
//    0x4050D093 (srai x1,x1,5) -> SRA, B=5.
//    0x12345097 (auipc) with pc=0x100 -> A=0x100, B=0x12345000.
//  4 Illegal: 0x02208033 (mul) and 0x0000006F (jal).
//    Required: out_illegal=1, alu_e=0, wb_en=0, delivered in order.
//  5 Backpressure: 3 back-to-back legal bundles, out_ready=0.
//    Required: after 2 accepts in_ready=0 and the third is held. Raising out_ready delivers all 3 in order, none lost or duplicated.
//  6 Flush: state TWO with flush=1 and in_valid=1 in the same cycle.
//    Required: next cycle out_valid=0, in_ready=1, and the incoming bundle is never issued.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: ALU opcodes, RV32I decode constants and skid-buffer state shared by the issue stage.
package alu_issue_stage_pkg;
  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_SLL = 5'd2,
    ALU_LTS = 5'd3,
    ALU_LTU = 5'd4,
    ALU_XOR = 5'd5,
    ALU_SRL = 5'd6,
    ALU_SRA = 5'd7,
    ALU_OR  = 5'd8,
    ALU_AND = 5'd9
  } alu_op_e;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} skid_state_e;
  // alt selects SUB for funct3 000 and SRA for funct3 101
  function automatic alu_op_e f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_LTS;
      F3_SLTU: return ALU_LTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_issue_skid.sv
// alu_issue_skid: generic 2-entry valid/ready skid buffer with registered in_ready and flush.
module alu_issue_skid
  import alu_issue_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  skid_state_e state_q, state_d;
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic in_ready_q;
  logic push, pop;
  assign push = in_valid && in_ready_q && !flush;
  assign pop = out_valid && out_ready;
  assign in_ready = in_ready_q;
  assign out_valid = state_q != S_EMPTY;
  assign out_data = head_q;
  always_comb begin
    state_d = state_q;
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      S_EMPTY: if (push) begin
        state_d = S_ONE;
        head_d = in_data;
      end
      S_ONE: if (push && pop) head_d = in_data;
      else if (push) begin
        state_d = S_TWO;
        tail_d = in_data;
      end else if (pop) state_d = S_EMPTY;
      S_TWO: if (pop) begin
        state_d = S_ONE;
        head_d = tail_q;
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      head_q <= '0;
      tail_q <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      in_ready_q <= state_d != S_TWO;
    end
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I OP/OP-IMM/LUI/AUIPC into a registered ALU bundle behind a skid buffer.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_val,
  input  logic [DATA_WIDTH-1:0] in_rs2_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  alu_e,
  output logic [4:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [4:0]            out_rd,
  output logic                  out_wb_en,
  output logic                  out_illegal
);
  localparam int BW = 2 * DATA_WIDTH + 13;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic legal, alt, is_shift, is_upper, e_raw;
  logic [DATA_WIDTH-1:0] a, b, imm_i, imm_u, shamt;
  logic [BW-1:0] dec_bundle, head;
  alu_op_e op;
  assign opc = in_instr[6:0];
  assign rd = in_instr[11:7];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  assign imm_i = DATA_WIDTH'($signed(in_instr[31:20]));
  assign imm_u = DATA_WIDTH'($signed({in_instr[31:12], 12'b0}));
  assign shamt = DATA_WIDTH'(in_instr[24:20]);
  assign is_shift = f3 == F3_SLL || f3 == F3_SR;
  assign is_upper = opc == OPC_LUI || opc == OPC_AUIPC;
  always_comb begin
    legal = 1'b0;
    alt = 1'b0;
    a = '0;
    b = '0;
    case (opc)
      OPC_OP: begin
        legal = f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
        alt = f7 == F7_ALT;
        a = in_rs1_val;
        b = in_rs2_val;
      end
      OPC_OPIMM: begin
        legal = f3 == F3_SLL ? f7 == F7_BASE : f3 == F3_SR ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
        alt = f3 == F3_SR && f7 == F7_ALT;
        a = in_rs1_val;
        b = is_shift ? shamt : imm_i;
      end
      OPC_LUI: begin
        legal = 1'b1;
        b = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        a = in_pc;
        b = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end
  assign op = is_upper ? ALU_ADD : f3_op(f3, alt);
  // illegal bundles still flow in order, but carry a neutral ADD 0,0 payload
  assign dec_bundle = {legal, legal ? op : ALU_ADD, legal ? a : '0, legal ? b : '0,
                       rd, legal && rd != 5'd0, !legal};
  alu_issue_skid #(.W(BW)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(dec_bundle),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(head)
  );
  assign {e_raw, alu_op, alu_a, alu_b, out_rd, out_wb_en, out_illegal} = head;
  assign alu_e = out_valid && e_raw;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: table-driven decode checks plus reset, backpressure and flush sequences.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic alu_e, out_wb_en, out_illegal;
  logic [4:0] alu_op, out_rd;
  logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val, alu_a, alu_b;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_e(alu_e), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_illegal(out_illegal)
  );
  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic e;
    alu_op_e op;
    logic [31:0] a, b;
    logic [4:0] rd;
    logic wb, ill;
  } vec_t;
  vec_t vecs[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
    in_instr = instr;
    in_pc = pc;
    in_rs1_val = r1;
    in_rs2_val = r2;
    in_valid = 1'b1;
  endtask
  function automatic logic [31:0] addi(input int n);
    return (32'(n) << 20) | (32'(n) << 7) | 32'h13;
  endfunction
  initial begin
    vecs[0]  = '{32'h40208033, 0, 5, 7, 1, ALU_SUB, 5, 7, 0, 0, 0};
    vecs[1]  = '{32'hFFF00093, 0, 0, 9, 1, ALU_ADD, 0, 32'hFFFFFFFF, 1, 1, 0};
    vecs[2]  = '{32'h4050D093, 0, 32'h80000000, 9, 1, ALU_SRA, 32'h80000000, 5, 1, 1, 0};
    vecs[3]  = '{32'h12345097, 32'h100, 3, 4, 1, ALU_ADD, 32'h100, 32'h12345000, 1, 1, 0};
    vecs[4]  = '{32'h02208033, 0, 5, 7, 0, ALU_ADD, 0, 0, 0, 0, 1};
    vecs[5]  = '{32'h0000006F, 32'h40, 5, 7, 0, ALU_ADD, 0, 0, 0, 0, 1};
    vecs[6]  = '{32'hFFFFF2B7, 32'h80, 123, 7, 1, ALU_ADD, 0, 32'hFFFFF000, 5, 1, 0};
    vecs[7]  = '{32'h005241B3, 0, 32'hAAAA5555, 32'h0F0F0F0F, 1, ALU_XOR, 32'hAAAA5555, 32'h0F0F0F0F, 3, 1, 0};
    vecs[8]  = '{32'h8000B113, 0, 42, 7, 1, ALU_LTU, 42, 32'hFFFFF800, 2, 1, 0};
    vecs[9]  = '{32'h40309093, 0, 42, 7, 0, ALU_ADD, 0, 0, 1, 0, 1};
    vecs[10] = '{32'h01F0D093, 0, 42, 7, 1, ALU_SRL, 42, 31, 1, 1, 0};
    vecs[11] = '{32'h4083D333, 0, 32'hDEADBEEF, 32'h12, 1, ALU_SRA, 32'hDEADBEEF, 32'h12, 6, 1, 0};
    vecs[12] = '{32'h4083F333, 0, 32'hDEADBEEF, 32'h12, 0, ALU_ADD, 0, 0, 6, 0, 1};
    vecs[13] = '{32'h00001093, 0, 8, 9, 1, ALU_SLL, 8, 0, 1, 1, 0};
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(32'h00100093, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_alu_e", 32'(alu_e), 0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", 32'(in_ready), 1);
    chk("rel_out_valid", 32'(out_valid), 0);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 1);
      drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d_alu_e", i), 32'(alu_e), 32'(vecs[i].e));
      chk($sformatf("v%0d_op", i), 32'(alu_op), 32'(vecs[i].op));
      chk($sformatf("v%0d_a", i), alu_a, vecs[i].a);
      chk($sformatf("v%0d_b", i), alu_b, vecs[i].b);
      chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_wb", i), 32'(out_wb_en), 32'(vecs[i].wb));
      chk($sformatf("v%0d_ill", i), 32'(out_illegal), 32'(vecs[i].ill));
    end
    tick();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_alu_e", 32'(alu_e), 0);
    out_ready = 1'b0;
    drive(addi(11), 0, 0, 0);
    tick();
    chk("bp_ready1", 32'(in_ready), 1);
    drive(addi(12), 0, 0, 0);
    tick();
    chk("bp_ready2", 32'(in_ready), 0);
    drive(addi(13), 0, 0, 0);
    tick();
    chk("bp_held_ready", 32'(in_ready), 0);
    chk("bp_head_rd", 32'(out_rd), 11);
    chk("bp_head_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    chk("bp_second_rd", 32'(out_rd), 12);
    chk("bp_second_b", alu_b, 12);
    tick();
    in_valid = 1'b0;
    chk("bp_third_rd", 32'(out_rd), 13);
    chk("bp_third_valid", 32'(out_valid), 1);
    tick();
    chk("bp_empty", 32'(out_valid), 0);
    out_ready = 1'b0;
    drive(addi(21), 0, 0, 0);
    tick();
    drive(addi(22), 0, 0, 0);
    tick();
    chk("fl_two", 32'(in_ready), 0);
    drive(addi(23), 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_in_ready", 32'(in_ready), 1);
    chk("fl_alu_e", 32'(alu_e), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_issue", 32'(out_valid), 0);
    end
    drive(addi(24), 0, 0, 0);
    tick();
    in_valid = 1'b0;
    chk("fl_after_valid", 32'(out_valid), 1);
    chk("fl_after_rd", 32'(out_rd), 24);
    tick();
    chk("fl_after_empty", 32'(out_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
